// File: rtl/mtn_ctrl_if.sv
// Motion-controller command/heading bus.
// The master side (the sequencer that drives the controller) issues go/stp
// and heading samples; the slave side (mtn_ctrl) returns the heading error
// and the PID drive commands.
interface mtn_ctrl_if;
    logic               go;
    logic               stp;
    logic signed [11:0] dsrd_hdng;
    logic signed [11:0] actl_hdng;
    logic               hdng_vld;
    logic signed [11:0] err;
    logic               err_vld;
    logic               moving;
    logic        [9:0]  frwrd;
    logic               at_hdng;
    logic               tmo_err;

    modport master (
        output go, stp, dsrd_hdng, actl_hdng, hdng_vld,
        input  err, err_vld, moving, frwrd, at_hdng, tmo_err
    );

    modport slave (
        input  go, stp, dsrd_hdng, actl_hdng, hdng_vld,
        output err, err_vld, moving, frwrd, at_hdng, tmo_err
    );
endinterface

// File: rtl/mtn_ctrl.sv
// Motion controller: ramps a forward-speed command up to cruise and back down
// on go/stp requests, and turns heading samples into a PID error strobe.
// Optional feature: define HDNG_TMO_EN to add a heading-sample watchdog that
// forces a ramp-down (and raises a sticky tmo_err) when no heading sample
// arrives for TMO_CYC clocks while moving.
module mtn_ctrl #(
    parameter logic [9:0]  RAMP_INC = 10'd16,
    parameter int          RAMP_DIV = 6,
    parameter logic [9:0]  MAX_SPD  = 10'h2A0,
    parameter logic [11:0] AT_THR   = 12'd32,
    parameter logic [15:0] TMO_CYC  = 16'd50000
) (
    input  logic      clk,
    input  logic      rst_n,
    mtn_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RAMP_UP = 2'd1,
        CRUISE  = 2'd2,
        RAMP_DN = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_nxt_state;
    logic [RAMP_DIV-1:0] r_presc;
    logic [9:0]          r_frwrd;
    logic [9:0]          w_nxt_frwrd;
    logic                r_moving;
    logic signed [11:0]  r_err;
    logic                r_err_vld;
    logic                r_at_hdng;
    logic                w_tick;
    logic                w_go_idle;
    logic                w_tmo_hit;
    logic                w_tmo_lock;
    logic [10:0]         w_up_sum;
    logic [11:0]         w_diff;
    logic [12:0]         w_mag;

    // A ramp tick is the cycle on which the prescaler is about to wrap to 0.
    assign w_tick    = (r_presc == {RAMP_DIV{1'b1}});
    assign w_go_idle = (r_state == IDLE) && bus.go && !bus.stp;

    // 11-bit sum so the step past MAX_SPD cannot wrap before clamping.
    assign w_up_sum  = {1'b0, r_frwrd} + {1'b0, RAMP_INC};

    // Heading error wraps modulo 2^12; the magnitude is one bit wider so
    // that 12'h800 comes out as 2048 instead of folding back negative.
    assign w_diff = bus.dsrd_hdng - bus.actl_hdng;
    assign w_mag  = w_diff[11] ? (~{1'b1, w_diff} + 13'd1) : {1'b0, w_diff};

`ifdef HDNG_TMO_EN
    logic [15:0] r_tmo_cnt;
    logic        r_tmo_err;

    assign w_tmo_hit  = (r_state != IDLE) && (r_tmo_cnt == TMO_CYC);
    assign w_tmo_lock = r_tmo_err;
    assign bus.tmo_err = r_tmo_err;

    // Watchdog: counts moving cycles since the last heading sample and parks
    // at the limit so the timeout cannot re-trigger by wrapping around.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo_cnt <= 16'd0;
        end else if ((r_state == IDLE) || bus.hdng_vld) begin
            r_tmo_cnt <= 16'd0;
        end else if (r_moving && (r_tmo_cnt != TMO_CYC)) begin
            r_tmo_cnt <= r_tmo_cnt + 16'd1;
        end
    end

    // Sticky timeout flag, only cleared by a fresh start from IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo_err <= 1'b0;
        end else if (w_tmo_hit) begin
            r_tmo_err <= 1'b1;
        end else if (w_go_idle) begin
            r_tmo_err <= 1'b0;
        end
    end
`else
    // No watchdog in this build; the limit is folded into a constant-false
    // term so the parameter list stays the same in both builds.
    assign w_tmo_hit   = (TMO_CYC == 16'd0) && 1'b0;
    assign w_tmo_lock  = 1'b0;
    assign bus.tmo_err = 1'b0;
`endif

    // Next-state and next-speed decision; stp always beats go.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_frwrd = r_frwrd;
        case (r_state)
            IDLE: begin
                w_nxt_frwrd = 10'd0;
                if (bus.go && !bus.stp) begin
                    w_nxt_state = RAMP_UP;
                end
            end
            RAMP_UP: begin
                if (bus.stp || w_tmo_hit) begin
                    w_nxt_state = RAMP_DN;
                end else if (w_tick) begin
                    if (w_up_sum >= {1'b0, MAX_SPD}) begin
                        w_nxt_frwrd = MAX_SPD;
                        w_nxt_state = CRUISE;
                    end else begin
                        w_nxt_frwrd = w_up_sum[9:0];
                    end
                end
            end
            CRUISE: begin
                w_nxt_frwrd = MAX_SPD;
                if (bus.stp || w_tmo_hit) begin
                    w_nxt_state = RAMP_DN;
                end
            end
            RAMP_DN: begin
                if (bus.go && !bus.stp && !w_tmo_lock && !w_tmo_hit) begin
                    w_nxt_state = RAMP_UP;
                end else if (w_tick) begin
                    if (r_frwrd <= RAMP_INC) begin
                        w_nxt_frwrd = 10'd0;
                        w_nxt_state = IDLE;
                    end else begin
                        w_nxt_frwrd = r_frwrd - RAMP_INC;
                    end
                end
            end
            default: begin
                w_nxt_state = IDLE;
                w_nxt_frwrd = 10'd0;
            end
        endcase
    end

    // State, speed and moving registers; moving follows the state it enters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_frwrd  <= 10'd0;
            r_moving <= 1'b0;
        end else begin
            r_state  <= w_nxt_state;
            r_frwrd  <= w_nxt_frwrd;
            r_moving <= (w_nxt_state != IDLE);
        end
    end

    // Ramp prescaler restarts on every state change so each ramp phase gets
    // a full tick period before its first step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
        end else if (w_nxt_state != r_state) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + RAMP_DIV'(1);
        end
    end

    // Heading error, its at-heading flag and the PID strobe (only when moving).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err     <= 12'sd0;
            r_at_hdng <= 1'b0;
            r_err_vld <= 1'b0;
        end else begin
            if (bus.hdng_vld) begin
                r_err     <= w_diff;
                r_at_hdng <= (w_mag < {1'b0, AT_THR});
            end
            r_err_vld <= bus.hdng_vld && r_moving;
        end
    end

    assign bus.err     = r_err;
    assign bus.err_vld = r_err_vld;
    assign bus.moving  = r_moving;
    assign bus.frwrd   = r_frwrd;
    assign bus.at_hdng = r_at_hdng;

endmodule
